scalar_mult_ctrl: RTL and testbench
===================================

SCALAR_MULT_CTRL -- requirements
Module: scalar_mult_ctrl

Interface
REQ-001 The block SHALL have parameter n, default 10, giving the field/scalar width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous active-low reset (0 = reset asserted).
REQ-004 The block SHALL have ports start (input, 1: one-cycle request), p (input, n: prime modulus) and k (input, n: scalar).
REQ-005 The block SHALL have ports xp and yp, input, n each: base point P.
REQ-006 The block SHALL have ports busy (output, 1), done (output, 1: one-cycle completion pulse), xq and yq (output, n each: result Q = kP), q_inf (output, 1: Q is the point at infinity) and err (output, 1: adder timeout).
REQ-007 The block SHALL have adder-side outputs pa_reset (1: active-high launch pulse), pa_p (n), pa_x1, pa_y1, pa_x2 and pa_y2 (n each).
REQ-008 The block SHALL have adder-side inputs pa_x3 and pa_y3 (n each), pa_ready (1) and pa_inf (1); the external adder SHALL handle doubling when both operands are equal.

Function
REQ-009 The FSM SHALL have states IDLE, SCAN, LAUNCH, WAIT, CAPTURE and FINISH, plus an internal op flag (DBL/ADD).
REQ-010 In IDLE with start=1, it SHALL latch p, k, xp and yp, set Q=infinity, set bit index i=n-1 and op=DBL, then enter SCAN; start SHALL be ignored when not IDLE.
REQ-011 In SCAN, for op=DBL: if Q is infinity, it SHALL skip the adder and set op=ADD; otherwise it SHALL go to LAUNCH with operands (Q,Q).
REQ-012 In SCAN, for op=ADD: if k[i]=0, it SHALL advance; if k[i]=1 and Q is infinity, it SHALL set Q=P without an adder call and advance; otherwise it SHALL go to LAUNCH with operands (Q,P).
REQ-013 Advance SHALL mean: if i=0, go to FINISH; else decrement i, set op=DBL and stay in SCAN.
REQ-014 LAUNCH SHALL drive pa_reset=1 for exactly one cycle with operands held stable from LAUNCH through CAPTURE, then enter WAIT.
REQ-015 WAIT SHALL persist until pa_ready=1 or pa_inf=1, then enter CAPTURE.
REQ-016 CAPTURE (one cycle after detection) SHALL load Q from pa_x3/pa_y3 with q_inf=0, or set q_inf=1 and Q coordinates to 0 if pa_inf was seen.
REQ-017 After CAPTURE, a DBL op SHALL set op=ADD and return to SCAN, and an ADD op SHALL advance per REQ-013.
REQ-018 FINISH SHALL drive xq/yq/q_inf as the final Q, pulse done for one cycle, and return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 xq, yq and q_inf SHALL hold their last result until the next FINISH.
REQ-021 pa_p SHALL equal the latched p.
REQ-022 k=0 SHALL produce q_inf=1 and xq=yq=0 with no adder calls.
REQ-023 A done pulse and start in the same cycle SHALL leave start ignored, since the FSM is not IDLE.

Reset
REQ-024 While reset=0, the block SHALL be in IDLE with busy=0, done=0, err=0, q_inf=1, xq=yq=0, pa_reset=0 and all pa_x/pa_y outputs at 0.
REQ-025 Reset asserted mid-operation SHALL abort immediately with no done pulse.

Configuration
REQ-026 With SCALAR_MULT_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-027 With SCALAR_MULT_TIMEOUT_EN defined, reaching 65535 in WAIT SHALL go to FINISH with err=1, q_inf=1 and xq=yq=0.
REQ-028 With SCALAR_MULT_TIMEOUT_EN defined, err SHALL clear on the next accepted start.
REQ-029 Without SCALAR_MULT_TIMEOUT_EN, no counter SHALL exist, err SHALL be tied to 0, and WAIT SHALL be unbounded.

Verification (curve y^2=x^3+2x+2 mod 17, P=(5,1), real point_addition or a behavioural adder model)
REQ-030 The bench SHALL cover: p=17, k=1 -> done with (5,1), q_inf=0, zero pa_reset pulses.
REQ-031 The bench SHALL cover: k=2 -> (6,3), exactly one pa_reset pulse.
REQ-032 The bench SHALL cover: k=3 -> (10,6), two adder calls.
REQ-033 The bench SHALL cover: k=19 -> q_inf=1, xq=yq=0; and k=0 -> q_inf=1 with no adder calls.
REQ-034 The bench SHALL cover: reset=0 during WAIT of k=3 -> busy=0 and no done; a new start with k=2 afterwards -> (6,3).
REQ-035 The bench SHALL cover: with SCALAR_MULT_TIMEOUT_EN, an adder model that never responds -> done with err=1 after 65535 WAIT cycles.

Source files
------------

// File: rtl/scalar_mult_ctrl.sv
// rtl/scalar_mult_ctrl.sv - double-and-add scalar multiplication sequencer driving an external point adder
// Optional adder watchdog: define SCALAR_MULT_TIMEOUT_EN.
module scalar_mult_ctrl #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] k,
  input  logic [n-1:0] xp,
  input  logic [n-1:0] yp,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] xq,
  output logic [n-1:0] yq,
  output logic         q_inf,
  output logic         err,
  output logic         pa_reset,
  output logic [n-1:0] pa_p,
  output logic [n-1:0] pa_x1,
  output logic [n-1:0] pa_y1,
  output logic [n-1:0] pa_x2,
  output logic [n-1:0] pa_y2,
  input  logic [n-1:0] pa_x3,
  input  logic [n-1:0] pa_y3,
  input  logic         pa_ready,
  input  logic         pa_inf
);

  localparam int IW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, LAUNCH, WAIT, CAPTURE, FINISH} state_t;
  typedef enum logic {DBL, ADD} op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [IW-1:0] i_q, i_d;
  logic [n-1:0]  p_q, p_d, k_q, k_d, xp_q, xp_d, yp_q, yp_d;
  logic [n-1:0]  qx_q, qx_d, qy_q, qy_d;
  logic          qinf_q, qinf_d;
  logic [n-1:0]  rx_q, rx_d, ry_q, ry_d;
  logic          rinf_q, rinf_d;
  logic [n-1:0]  x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [n-1:0]  xq_q, xq_d, yq_q, yq_d;
  logic          qinfo_q, qinfo_d;
  logic          advance;
`ifdef SCALAR_MULT_TIMEOUT_EN
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= DBL;
      i_q     <= '0;
      p_q     <= '0;
      k_q     <= '0;
      xp_q    <= '0;
      yp_q    <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      qinf_q  <= 1'b1;
      rx_q    <= '0;
      ry_q    <= '0;
      rinf_q  <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      xq_q    <= '0;
      yq_q    <= '0;
      qinfo_q <= 1'b1;
`ifdef SCALAR_MULT_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      i_q     <= i_d;
      p_q     <= p_d;
      k_q     <= k_d;
      xp_q    <= xp_d;
      yp_q    <= yp_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      qinf_q  <= qinf_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rinf_q  <= rinf_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      xq_q    <= xq_d;
      yq_q    <= yq_d;
      qinfo_q <= qinfo_d;
`ifdef SCALAR_MULT_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    i_d     = i_q;
    p_d     = p_q;
    k_d     = k_q;
    xp_d    = xp_q;
    yp_d    = yp_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    qinf_d  = qinf_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rinf_d  = rinf_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x2_d    = x2_q;
    y2_d    = y2_q;
    xq_d    = xq_q;
    yq_d    = yq_q;
    qinfo_d = qinfo_q;
    advance = 1'b0;
`ifdef SCALAR_MULT_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          p_d     = p;
          k_d     = k;
          xp_d    = xp;
          yp_d    = yp;
          qx_d    = '0;
          qy_d    = '0;
          qinf_d  = 1'b1;
          i_d     = IW'(n - 1);
          op_d    = DBL;
          state_d = SCAN;
`ifdef SCALAR_MULT_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      SCAN: begin
        if (op_q == DBL) begin
          // Doubling infinity is still infinity, so no adder round trip is needed.
          if (qinf_q) begin
            op_d = ADD;
          end else begin
            x1_d    = qx_q;
            y1_d    = qy_q;
            x2_d    = qx_q;
            y2_d    = qy_q;
            state_d = LAUNCH;
          end
        end else if (!k_q[i_q]) begin
          advance = 1'b1;
        end else if (qinf_q) begin
          qx_d    = xp_q;
          qy_d    = yp_q;
          qinf_d  = 1'b0;
          advance = 1'b1;
        end else begin
          x1_d    = qx_q;
          y1_d    = qy_q;
          x2_d    = xp_q;
          y2_d    = yp_q;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef SCALAR_MULT_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (pa_ready || pa_inf) begin
          rx_d    = pa_x3;
          ry_d    = pa_y3;
          rinf_d  = pa_inf;
          state_d = CAPTURE;
        end
`ifdef SCALAR_MULT_TIMEOUT_EN
        else if (cnt_q == 16'hFFFF) begin
          qx_d    = '0;
          qy_d    = '0;
          qinf_d  = 1'b1;
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      CAPTURE: begin
        if (rinf_q) begin
          qx_d   = '0;
          qy_d   = '0;
          qinf_d = 1'b1;
        end else begin
          qx_d   = rx_q;
          qy_d   = ry_q;
          qinf_d = 1'b0;
        end
        if (op_q == DBL) begin
          op_d    = ADD;
          state_d = SCAN;
        end else begin
          advance = 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (i_q == '0) begin
        state_d = FINISH;
      end else begin
        i_d     = i_q - IW'(1);
        op_d    = DBL;
        state_d = SCAN;
      end
    end

    // Result registers update as FINISH is entered so they are valid alongside done.
    if (state_d == FINISH && state_q != FINISH) begin
      xq_d    = qx_d;
      yq_d    = qy_d;
      qinfo_d = qinf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign pa_reset = (state_q == LAUNCH);
  assign pa_p     = p_q;
  assign pa_x1    = x1_q;
  assign pa_y1    = y1_q;
  assign pa_x2    = x2_q;
  assign pa_y2    = y2_q;
  assign xq       = xq_q;
  assign yq       = yq_q;
  assign q_inf    = qinfo_q;
`ifdef SCALAR_MULT_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// tb/tb_scalar_mult_ctrl.sv - randomized check of scalar_mult_ctrl on y^2=x^3+2x+2 mod 17, P=(5,1)
module tb_scalar_mult_ctrl;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] p = 10'd17, k = '0, xp = 10'd5, yp = 10'd1;
  logic         busy, done, q_inf, err, pa_reset, pa_ready = 1'b0, pa_inf = 1'b0;
  logic [N-1:0] xq, yq, pa_p, pa_x1, pa_y1, pa_x2, pa_y2;
  logic [N-1:0] pa_x3 = '0, pa_y3 = '0;

  int n_asserts = 0;
  int n_fail = 0;
  int calls = 0;
  int done_cnt = 0;
  int fixed_lat = 0;
  bit hang = 1'b0;

  scalar_mult_ctrl #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .p(p), .k(k), .xp(xp), .yp(yp),
    .busy(busy), .done(done), .xq(xq), .yq(yq), .q_inf(q_inf), .err(err),
    .pa_reset(pa_reset), .pa_p(pa_p), .pa_x1(pa_x1), .pa_y1(pa_y1),
    .pa_x2(pa_x2), .pa_y2(pa_y2), .pa_x3(pa_x3), .pa_y3(pa_y3),
    .pa_ready(pa_ready), .pa_inf(pa_inf)
  );

  always #5 clk = ~clk;

  function automatic int md(input int a);
    return ((a % 17) + 17) % 17;
  endfunction

  function automatic int inv(input int a);
    int r = 1;
    repeat (15) r = md(r * a);
    return r;
  endfunction

  // Affine point addition on the test curve, infinity carried as a flag.
  task automatic padd(input int x1, input int y1, input int i1, input int x2, input int y2,
                      input int i2, output int x3, output int y3, output int i3);
    int lam;
    if (i1 != 0) begin x3 = x2; y3 = y2; i3 = i2; end
    else if (i2 != 0) begin x3 = x1; y3 = y1; i3 = i1; end
    else if (x1 == x2 && md(y1 + y2) == 0) begin x3 = 0; y3 = 0; i3 = 1; end
    else begin
      if (x1 == x2) lam = md(md(3 * x1 * x1 + 2) * inv(md(2 * y1)));
      else lam = md(md(y2 - y1) * inv(md(x2 - x1)));
      x3 = md(lam * lam - x1 - x2);
      y3 = md(lam * (x1 - x3) - y1);
      i3 = 0;
    end
  endtask

  // Reference kP by repeated addition; P has order 19.
  task automatic ref_mult(input int kk, output int x, output int y, output int i);
    int tx, ty, ti;
    x = 0; y = 0; i = 1;
    repeat (kk % 19) begin
      padd(x, y, i, 5, 1, 0, tx, ty, ti);
      x = tx; y = ty; i = ti;
    end
  endtask

  // Adder calls: one per doubling or addition whose accumulator multiple is nonzero mod 19.
  function automatic int ref_calls(input int kk);
    int v = 0, c = 0;
    for (int b = N - 1; b >= 0; b--) begin
      if (v % 19 != 0) c++;
      v = 2 * v;
      if (((kk >> b) & 1) != 0) begin
        if (v % 19 != 0) c++;
        v = v + 1;
      end
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin : adder_model
    int rx, ry, ri, lat;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && pa_reset === 1'b1) begin
        calls++;
        padd(int'(pa_x1), int'(pa_y1), 0, int'(pa_x2), int'(pa_y2), 0, rx, ry, ri);
        if (!hang) begin
          lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
          repeat (lat) @(negedge clk);
          pa_x3 = N'(rx); pa_y3 = N'(ry);
          pa_ready = (ri == 0); pa_inf = (ri != 0);
          @(negedge clk);
          pa_ready = 1'b0; pa_inf = 1'b0;
        end
      end
    end
  end

  initial begin : done_monitor
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic run(input int kk, input int bound, output bit got, output int cyc);
    @(negedge clk);
    k = N'(kk); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0; cyc = 0;
    while (!got && cyc < bound) begin
      if (done === 1'b1) got = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
  endtask

  initial begin : main
    bit got;
    int cyc, c0, d0, ex, ey, ei, kk;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_qinf", q_inf, 1);
    chk("rst_xq", xq, 0);
    chk("rst_yq", yq, 0);
    chk("rst_pa_reset", pa_reset, 0);
    chk("rst_pa_ops", pa_x1 | pa_y1 | pa_x2 | pa_y2, 0);
    reset = 1'b1;

    c0 = calls; run(1, 2000, got, cyc);
    chk("k1_done", got, 1);
    chk("k1_busy_at_done", busy, 1);
    chk("k1_x", xq, 5); chk("k1_y", yq, 1); chk("k1_inf", q_inf, 0);
    chk("k1_calls", calls - c0, 0);
    @(negedge clk);
    chk("k1_done_pulse", done, 0); chk("k1_idle", busy, 0);

    c0 = calls; run(2, 2000, got, cyc);
    chk("k2_done", got, 1);
    chk("k2_x", xq, 6); chk("k2_y", yq, 3); chk("k2_inf", q_inf, 0);
    chk("k2_calls", calls - c0, 1);
    chk("k2_pa_p", pa_p, 17);
    repeat (5) @(negedge clk);
    chk("k2_hold_x", xq, 6);

    c0 = calls; run(3, 2000, got, cyc);
    chk("k3_done", got, 1);
    chk("k3_x", xq, 10); chk("k3_y", yq, 6);
    chk("k3_calls", calls - c0, 2);
    d0 = done_cnt;
    k = N'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("start_at_done_ignored", done_cnt - d0, 0);
    chk("start_at_done_busy", busy, 0);
    chk("start_at_done_hold", xq, 10);

    c0 = calls; run(19, 2000, got, cyc);
    chk("k19_done", got, 1);
    chk("k19_inf", q_inf, 1); chk("k19_x", xq, 0); chk("k19_y", yq, 0);
    chk("k19_calls", calls - c0, ref_calls(19));

    c0 = calls; run(0, 2000, got, cyc);
    chk("k0_done", got, 1);
    chk("k0_inf", q_inf, 1); chk("k0_x", xq, 0);
    chk("k0_calls", calls - c0, 0);

    fixed_lat = 30;
    c0 = calls; d0 = done_cnt;
    @(negedge clk);
    k = N'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (calls == c0 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("abort_launch_seen", calls - c0, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_qinf", q_inf, 1);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    fixed_lat = 0;
    run(2, 2000, got, cyc);
    chk("post_abort_done", got, 1);
    chk("post_abort_x", xq, 6); chk("post_abort_y", yq, 3);

    for (int t = 0; t < 10; t++) begin
      kk = int'($urandom_range(0, 1023));
      ref_mult(kk, ex, ey, ei);
      c0 = calls; run(kk, 4000, got, cyc);
      chk($sformatf("rnd%0d_k%0d_done", t, kk), got, 1);
      chk($sformatf("rnd%0d_k%0d_inf", t, kk), q_inf, ei);
      chk($sformatf("rnd%0d_k%0d_x", t, kk), xq, ex);
      chk($sformatf("rnd%0d_k%0d_y", t, kk), yq, ey);
      chk($sformatf("rnd%0d_k%0d_calls", t, kk), calls - c0, ref_calls(kk));
    end

`ifdef SCALAR_MULT_TIMEOUT_EN
    hang = 1'b1;
    run(2, 70000, got, cyc);
    chk("to_done", got, 1);
    chk("to_long_wait", (cyc >= 65535), 1);
    chk("to_err", err, 1); chk("to_inf", q_inf, 1); chk("to_x", xq, 0);
    hang = 1'b0;
    repeat (3) @(negedge clk);
    run(1, 2000, got, cyc);
    chk("to_clear_done", got, 1);
    chk("to_clear_err", err, 0); chk("to_clear_x", xq, 5);
`else
    chk("err_tied_low", err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
